alu_issue_ctrl: RTL and testbench
=================================

# alu_issue_ctrl

Multi-cycle decode/issue controller that drives the CPU's 12-bit one-hot ALU operation bus and consumes its result. It accepts one 32-bit MIPS ALU-class instruction plus its register operands through a valid/ready handshake. It decodes the instruction and presents the registered operation code and operands to the combinational ALU. It then captures the ALU result and returns it on a writeback handshake toward the register file.

## Interface
- No parameters; all widths fixed (32-bit datapath, 5-bit register index, 12-bit op bus).
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- inst_valid  in  1  instruction and operands valid
- inst_ready  out  1  controller can accept; high only in IDLE and reset deasserted
- inst  in  32  instruction word
- rs_data  in  32  GPR[rs], sampled with inst
- rt_data  in  32  GPR[rt], sampled with inst
- alu_op  out  12  one-hot op: bit0 add, 1 sub, 2 slt, 3 sltu, 4 and, 5 nor, 6 or, 7 xor, 8 sll, 9 srl, 10 sra, 11 lui
- alu_src1  out  32  ALU operand 1 (shift amount in [4:0] for shifts)
- alu_src2  out  32  ALU operand 2 (shifted value for shifts)
- alu_result  in  32  combinational ALU result
- wb_valid  out  1  writeback record valid
- wb_ready  in  1  writeback consumer accepts
- wb_we  out  1  register write enable
- wb_dest  out  5  destination register
- wb_data  out  32  captured result
- wb_illegal  out  1  instruction not supported; no write
- wb_ovf  out  1  signed overflow trap; no write (only with ALU_ISSUE_OVF_EN)

## Operation
- FSM states: IDLE, DEC, EXE, WB.
  - IDLE: inst_valid&inst_ready → capture inst/rs_data/rt_data → DEC.
  - DEC: decode and register alu_op/src1/src2/dest → EXE; illegal → WB directly with wb_illegal=1 and alu_op=0.
  - EXE: capture alu_result → wb_data; evaluate overflow → WB; clear alu_op to 0 on exit.
  - WB: wb_valid=1; wb_valid&wb_ready → IDLE.
- R-type (opcode 0): funct 0x20 add, 0x21 addu → add; 0x22 sub, 0x23 subu → sub; 0x2A slt; 0x2B sltu; 0x24 and; 0x25 or; 0x26 xor; 0x27 nor. For these, src1=rs_data, src2=rt_data. For shifts 0x00 sll, 0x02 srl, 0x03 sra: src1={27'b0,shamt}, src2=rt_data. For 0x04 sllv, 0x06 srlv, 0x07 srav: src1=rs_data, src2=rt_data. Dest for all R-type is rd.
- I-type, dest rt, src1=rs_data:
  - 0x08 addi and 0x09 addiu → add, src2 sign-extended.
  - 0x0A slti and 0x0B sltiu → slt/sltu, src2 sign-extended.
  - 0x0C andi, 0x0D ori, 0x0E xori → src2 zero-extended.
  - 0x0F lui: src1=0, src2={16'b0,imm}.
- Any other opcode/funct is illegal: wb_we=0, wb_illegal=1.
- Dest 0: wb_we=0, record still delivered normally.
- Exactly one alu_op bit is high in EXE; all zero in every other state.

## Timing
- Accept at edge E0; DEC during E0–E1; alu_op/src valid during EXE (E1–E2); wb_valid high from E2. Illegal instructions: wb_valid from E1.
- Minimum issue interval 4 cycles with wb_ready held high. Only one instruction is in flight.
- WB outputs hold stable while wb_valid & !wb_ready. inst_ready stays 0 outside IDLE.
- Reset (any state, any cycle): state=IDLE; alu_op, alu_src1, alu_src2, wb_valid, wb_we, wb_dest, wb_data, wb_illegal, wb_ovf all 0; inst_ready=0 while reset is high. An in-flight instruction is discarded with no writeback.

## Configuration
- ALU_ISSUE_OVF_EN defined: add/addi/sub flag signed overflow in EXE.
  - add/addi overflow: src1[31]==src2[31] and result[31]!=src1[31].
  - sub overflow: src1[31]!=src2[31] and result[31]!=src1[31].
  - On overflow: wb_ovf=1, wb_we=0.
- Undefined: add/addi/sub behave exactly as addu/addiu/subu; wb_ovf tied 0.

## Test plan
- addu $3,$1,$2 (0x00221821), rs=5, rt=7 → EXE alu_op=0x001; wb_valid 2 cycles after accept; wb_dest=3, wb_data=12, wb_we=1.
- sra $4,$2,4 (0x00022103), rt=0x80000000 → alu_op=0x400, src1=4; wb_data=0xF8000000.
- lui $5,0x1234 (0x3C051234) → alu_op=0x800, src2=0x00001234, wb_data=0x12340000. slti $6,$1,-1 (0x2826FFFF), rs=0xFFFFFFFE → src2=0xFFFFFFFF, wb_data=1.
- Hold wb_ready low 5 cycles in WB → wb_valid and record stable, inst_ready=0, no new accept. Assert reset mid-EXE → all outputs 0 next cycle; wb_valid never asserted.
- inst=0xFC000000 → wb_valid one cycle after DEC, wb_illegal=1, wb_we=0, alu_op stays 0.
- add $3,$1,$2 (0x00221820), rs=0x7FFFFFFF, rt=1:
  - With ALU_ISSUE_OVF_EN: wb_ovf=1, wb_we=0.
  - Without: wb_we=1, wb_data=0x80000000.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: multi-cycle decode/issue controller for MIPS ALU-class
// instructions driving a 12-bit one-hot ALU op bus.
//
// Ports:
//   clk, reset             rising-edge clock, async active-high reset
//   inst_valid/inst_ready  instruction + operand handshake (IDLE only)
//   inst, rs_data, rt_data instruction word and its register operands
//   alu_op                 one-hot op, nonzero only in EXE
//   alu_src1, alu_src2     ALU operands (src1[4:0] = shift amount)
//   alu_result             combinational ALU result, sampled in EXE
//   wb_valid/wb_ready      writeback handshake toward the register file
//   wb_we, wb_dest,        writeback record; held stable while stalled
//   wb_data, wb_illegal,
//   wb_ovf
//
// Optional feature: define ALU_ISSUE_OVF_EN to trap signed overflow on
// add/addi/sub (wb_ovf=1, no write). Otherwise wb_ovf is tied low.

module alu_issue_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_valid,
    output logic        inst_ready,
    input  logic [31:0] inst,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic [11:0] alu_op,
    output logic [31:0] alu_src1,
    output logic [31:0] alu_src2,
    input  logic [31:0] alu_result,
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic        wb_we,
    output logic [4:0]  wb_dest,
    output logic [31:0] wb_data,
    output logic        wb_illegal,
    output logic        wb_ovf
);

    localparam logic [11:0] OP_ADD  = 12'h001;
    localparam logic [11:0] OP_SUB  = 12'h002;
    localparam logic [11:0] OP_SLT  = 12'h004;
    localparam logic [11:0] OP_SLTU = 12'h008;
    localparam logic [11:0] OP_AND  = 12'h010;
    localparam logic [11:0] OP_NOR  = 12'h020;
    localparam logic [11:0] OP_OR   = 12'h040;
    localparam logic [11:0] OP_XOR  = 12'h080;
    localparam logic [11:0] OP_SLL  = 12'h100;
    localparam logic [11:0] OP_SRL  = 12'h200;
    localparam logic [11:0] OP_SRA  = 12'h400;
    localparam logic [11:0] OP_LUI  = 12'h800;

    typedef enum logic [1:0] {
        IDLE,
        DEC,
        EXE,
        WB
    } state_t;

    state_t state;
    state_t state_nxt;

    // Only the instruction fields actually used are kept; rs is
    // delivered as data so its index is not needed.
    logic [5:0]  opc_q;
    logic [4:0]  rt_q;
    logic [15:0] imm_q;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [4:0]  dest_q;

    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [31:0] imm_sx;
    logic [31:0] imm_zx;

    assign rd     = imm_q[15:11];
    assign shamt  = imm_q[10:6];
    assign funct  = imm_q[5:0];
    assign imm_sx = {{16{imm_q[15]}}, imm_q};
    assign imm_zx = {16'b0, imm_q};

    logic [11:0] dec_op;
    logic [31:0] dec_src1;
    logic [31:0] dec_src2;
    logic [4:0]  dec_dest;
    logic        dec_illegal;
    logic        exe_ovf;

    assign inst_ready = (state == IDLE) && !reset;

    // Decode of the captured instruction. An instruction is illegal
    // exactly when no operation bit was selected.
    always_comb begin
        dec_op   = '0;
        dec_src1 = rs_val;
        dec_src2 = rt_val;
        dec_dest = rd;
        case (opc_q)
            6'h00: begin
                case (funct)
                    6'h20, 6'h21: dec_op = OP_ADD;
                    6'h22, 6'h23: dec_op = OP_SUB;
                    6'h2A:        dec_op = OP_SLT;
                    6'h2B:        dec_op = OP_SLTU;
                    6'h24:        dec_op = OP_AND;
                    6'h25:        dec_op = OP_OR;
                    6'h26:        dec_op = OP_XOR;
                    6'h27:        dec_op = OP_NOR;
                    6'h00: begin
                        dec_op   = OP_SLL;
                        dec_src1 = {27'b0, shamt};
                    end
                    6'h02: begin
                        dec_op   = OP_SRL;
                        dec_src1 = {27'b0, shamt};
                    end
                    6'h03: begin
                        dec_op   = OP_SRA;
                        dec_src1 = {27'b0, shamt};
                    end
                    6'h04:        dec_op = OP_SLL;
                    6'h06:        dec_op = OP_SRL;
                    6'h07:        dec_op = OP_SRA;
                    default:      dec_op = '0;
                endcase
            end
            6'h08, 6'h09: begin
                dec_op   = OP_ADD;
                dec_src2 = imm_sx;
                dec_dest = rt_q;
            end
            6'h0A: begin
                dec_op   = OP_SLT;
                dec_src2 = imm_sx;
                dec_dest = rt_q;
            end
            6'h0B: begin
                dec_op   = OP_SLTU;
                dec_src2 = imm_sx;
                dec_dest = rt_q;
            end
            6'h0C: begin
                dec_op   = OP_AND;
                dec_src2 = imm_zx;
                dec_dest = rt_q;
            end
            6'h0D: begin
                dec_op   = OP_OR;
                dec_src2 = imm_zx;
                dec_dest = rt_q;
            end
            6'h0E: begin
                dec_op   = OP_XOR;
                dec_src2 = imm_zx;
                dec_dest = rt_q;
            end
            6'h0F: begin
                dec_op   = OP_LUI;
                dec_src1 = '0;
                dec_src2 = imm_zx;
                dec_dest = rt_q;
            end
            default: dec_op = '0;
        endcase
        dec_illegal = (dec_op == '0);
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (inst_valid) state_nxt = DEC;
            DEC:  state_nxt = dec_illegal ? WB : EXE;
            EXE:  state_nxt = WB;
            WB:   if (wb_ready) state_nxt = IDLE;
        endcase
    end

    // Datapath and writeback record
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            opc_q      <= '0;
            rt_q       <= '0;
            imm_q      <= '0;
            rs_val     <= '0;
            rt_val     <= '0;
            dest_q     <= '0;
            alu_op     <= '0;
            alu_src1   <= '0;
            alu_src2   <= '0;
            wb_valid   <= 1'b0;
            wb_we      <= 1'b0;
            wb_dest    <= '0;
            wb_data    <= '0;
            wb_illegal <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (inst_valid) begin
                        opc_q  <= inst[31:26];
                        rt_q   <= inst[20:16];
                        imm_q  <= inst[15:0];
                        rs_val <= rs_data;
                        rt_val <= rt_data;
                    end
                end
                DEC: begin
                    if (dec_illegal) begin
                        wb_valid   <= 1'b1;
                        wb_illegal <= 1'b1;
                        wb_we      <= 1'b0;
                        wb_dest    <= '0;
                        wb_data    <= '0;
                    end else begin
                        alu_op   <= dec_op;
                        alu_src1 <= dec_src1;
                        alu_src2 <= dec_src2;
                        dest_q   <= dec_dest;
                    end
                end
                EXE: begin
                    alu_op     <= '0;
                    wb_valid   <= 1'b1;
                    wb_illegal <= 1'b0;
                    wb_dest    <= dest_q;
                    wb_data    <= alu_result;
                    // $0 is hardwired zero: deliver the record, skip write
                    wb_we      <= (dest_q != 5'd0) && !exe_ovf;
                end
                WB: begin
                    if (wb_ready) begin
                        wb_valid   <= 1'b0;
                        wb_we      <= 1'b0;
                        wb_dest    <= '0;
                        wb_data    <= '0;
                        wb_illegal <= 1'b0;
                    end
                end
            endcase
        end
    end

`ifdef ALU_ISSUE_OVF_EN
    logic chk_add_d;
    logic chk_sub_d;
    logic chk_add_q;
    logic chk_sub_q;

    // Trapping forms only; addu/addiu/subu never trap
    assign chk_add_d = ((opc_q == 6'h00) && (funct == 6'h20))
                    || (opc_q == 6'h08);
    assign chk_sub_d = (opc_q == 6'h00) && (funct == 6'h22);

    assign exe_ovf =
        (chk_add_q && (alu_src1[31] == alu_src2[31])
                   && (alu_result[31] != alu_src1[31]))
     || (chk_sub_q && (alu_src1[31] != alu_src2[31])
                   && (alu_result[31] != alu_src1[31]));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chk_add_q <= 1'b0;
            chk_sub_q <= 1'b0;
            wb_ovf    <= 1'b0;
        end else begin
            if (state == DEC) begin
                chk_add_q <= chk_add_d;
                chk_sub_q <= chk_sub_d;
            end
            if (state == EXE) begin
                wb_ovf <= exe_ovf;
            end else if ((state == WB) && wb_ready) begin
                wb_ovf <= 1'b0;
            end
        end
    end
`else
    assign exe_ovf = 1'b0;
    assign wb_ovf  = 1'b0;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl: directed MIPS vectors, expected
// EXE operands and writeback records queued at issue, checked by a monitor.

module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [11:0] alu_op;
    logic [31:0] alu_src1;
    logic [31:0] alu_src2;
    logic [31:0] alu_result;
    logic        wb_valid;
    logic        wb_ready;
    logic        wb_we;
    logic [4:0]  wb_dest;
    logic [31:0] wb_data;
    logic        wb_illegal;
    logic        wb_ovf;

    always #5 clk = ~clk;

    alu_issue_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .inst       (inst),
        .rs_data    (rs_data),
        .rt_data    (rt_data),
        .alu_op     (alu_op),
        .alu_src1   (alu_src1),
        .alu_src2   (alu_src2),
        .alu_result (alu_result),
        .wb_valid   (wb_valid),
        .wb_ready   (wb_ready),
        .wb_we      (wb_we),
        .wb_dest    (wb_dest),
        .wb_data    (wb_data),
        .wb_illegal (wb_illegal),
        .wb_ovf     (wb_ovf)
    );

    // Combinational ALU that the controller drives
    always_comb begin
        alu_result = '0;
        case (alu_op)
            12'h001: alu_result = alu_src1 + alu_src2;
            12'h002: alu_result = alu_src1 - alu_src2;
            12'h004: alu_result = {31'b0, $signed(alu_src1) < $signed(alu_src2)};
            12'h008: alu_result = {31'b0, alu_src1 < alu_src2};
            12'h010: alu_result = alu_src1 & alu_src2;
            12'h020: alu_result = ~(alu_src1 | alu_src2);
            12'h040: alu_result = alu_src1 | alu_src2;
            12'h080: alu_result = alu_src1 ^ alu_src2;
            12'h100: alu_result = alu_src2 << alu_src1[4:0];
            12'h200: alu_result = alu_src2 >> alu_src1[4:0];
            12'h400: alu_result = $signed(alu_src2) >>> alu_src1[4:0];
            12'h800: alu_result = alu_src2 << 16;
            default: alu_result = '0;
        endcase
    end

    typedef struct {
        logic [11:0] op;
        logic [31:0] s1;
        logic [31:0] s2;
    } exe_t;

    typedef struct {
        logic [4:0]  dest;
        logic [31:0] data;
        logic        we;
        logic        ill;
        logic        ovf;
        int          lat;
    } wb_t;

    exe_t exe_q[$];
    wb_t  wb_q[$];
    exe_t e;
    wb_t  w;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int acc_cyc = 0;
    bit seen_wb = 1'b0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic exp_exe(logic [11:0] op, logic [31:0] s1, logic [31:0] s2);
        exe_t t;
        t.op = op;
        t.s1 = s1;
        t.s2 = s2;
        exe_q.push_back(t);
    endtask

    task automatic exp_wb(logic [4:0] dest, logic [31:0] data,
                          logic we, logic ill, logic ovf, int lat);
        wb_t t;
        t.dest = dest;
        t.data = data;
        t.we   = we;
        t.ill  = ill;
        t.ovf  = ovf;
        t.lat  = lat;
        wb_q.push_back(t);
    endtask

    // Monitor: lat is accept edge to first wb_valid edge, in cycles
    always @(negedge clk) begin
        cyc++;
        if (inst_valid && inst_ready) begin
            acc_cyc = cyc;
            seen_wb = 1'b0;
        end
        if (alu_op != 12'h000) begin
            if (exe_q.size() == 0) begin
                chk("unexpected alu_op", {20'b0, alu_op}, 32'h0);
            end else begin
                e = exe_q.pop_front();
                chk("alu_op", {20'b0, alu_op}, {20'b0, e.op});
                chk("alu_src1", alu_src1, e.s1);
                chk("alu_src2", alu_src2, e.s2);
                chk("inst_ready in exe", {31'b0, inst_ready}, 32'h0);
            end
        end
        if (wb_valid) begin
            if (wb_q.size() == 0) begin
                chk("unexpected wb_valid", {31'b0, wb_valid}, 32'h0);
            end else begin
                w = wb_q[0];
                if (!seen_wb) begin
                    chk("wb latency", cyc - acc_cyc - 1, w.lat);
                    seen_wb = 1'b1;
                end
                chk("wb_dest", {27'b0, wb_dest}, {27'b0, w.dest});
                chk("wb_data", wb_data, w.data);
                chk("wb_we", {31'b0, wb_we}, {31'b0, w.we});
                chk("wb_illegal", {31'b0, wb_illegal}, {31'b0, w.ill});
                chk("wb_ovf", {31'b0, wb_ovf}, {31'b0, w.ovf});
                chk("alu_op in wb", {20'b0, alu_op}, 32'h0);
                chk("inst_ready in wb", {31'b0, inst_ready}, 32'h0);
                if (wb_ready) void'(wb_q.pop_front());
            end
        end
    end

    task automatic issue(logic [31:0] i, logic [31:0] rs, logic [31:0] rt,
                         output int acc);
        int n;
        n = 0;
        @(posedge clk);
        #1;
        inst       = i;
        rs_data    = rs;
        rt_data    = rt;
        inst_valid = 1'b1;
        @(negedge clk);
        while (!inst_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!inst_ready) chk("accept timeout", {31'b0, inst_ready}, 32'h1);
        @(posedge clk);
        #1;
        acc        = acc_cyc;
        inst_valid = 1'b0;
        inst       = $urandom;
        rs_data    = $urandom;
        rt_data    = $urandom;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((wb_q.size() != 0 || exe_q.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain", wb_q.size() + exe_q.size(), 0);
    endtask

    task automatic chk_all_zero(string tag);
        chk({tag, " alu_op"}, {20'b0, alu_op}, 32'h0);
        chk({tag, " alu_src1"}, alu_src1, 32'h0);
        chk({tag, " alu_src2"}, alu_src2, 32'h0);
        chk({tag, " wb_valid"}, {31'b0, wb_valid}, 32'h0);
        chk({tag, " wb_we"}, {31'b0, wb_we}, 32'h0);
        chk({tag, " wb_dest"}, {27'b0, wb_dest}, 32'h0);
        chk({tag, " wb_data"}, wb_data, 32'h0);
        chk({tag, " wb_illegal"}, {31'b0, wb_illegal}, 32'h0);
        chk({tag, " wb_ovf"}, {31'b0, wb_ovf}, 32'h0);
        chk({tag, " inst_ready"}, {31'b0, inst_ready}, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0;
        int a1;
        reset      = 1'b1;
        inst_valid = 1'b0;
        inst       = '0;
        rs_data    = '0;
        rt_data    = '0;
        wb_ready   = 1'b1;
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("inst_ready idle", {31'b0, inst_ready}, 32'h1);

        // addu $3,$1,$2 then back-to-back sra $4,$2,4
        exp_exe(12'h001, 32'd5, 32'd7);
        exp_wb(5'd3, 32'd12, 1'b1, 1'b0, 1'b0, 2);
        issue(32'h00221821, 32'd5, 32'd7, a0);
        exp_exe(12'h400, 32'd4, 32'h80000000);
        exp_wb(5'd4, 32'hF8000000, 1'b1, 1'b0, 1'b0, 2);
        issue(32'h00022103, 32'h00001111, 32'h80000000, a1);
        chk("issue interval", a1 - a0, 4);

        // lui $5,0x1234
        exp_exe(12'h800, 32'h0, 32'h00001234);
        exp_wb(5'd5, 32'h12340000, 1'b1, 1'b0, 1'b0, 2);
        issue(32'h3C051234, 32'h0000DEAD, 32'h00005555, a0);

        // slti $6,$1,-1
        exp_exe(12'h004, 32'hFFFFFFFE, 32'hFFFFFFFF);
        exp_wb(5'd6, 32'd1, 1'b1, 1'b0, 1'b0, 2);
        issue(32'h2826FFFF, 32'hFFFFFFFE, 32'h0, a0);

        // ori $6,$1,0x8000 (zero-extended)
        exp_exe(12'h040, 32'h00000001, 32'h00008000);
        exp_wb(5'd6, 32'h00008001, 1'b1, 1'b0, 1'b0, 2);
        issue(32'h34268000, 32'h00000001, 32'h0, a0);

        // addiu $6,$1,-1
        exp_exe(12'h001, 32'd10, 32'hFFFFFFFF);
        exp_wb(5'd6, 32'd9, 1'b1, 1'b0, 1'b0, 2);
        issue(32'h2426FFFF, 32'd10, 32'h0, a0);

        // sllv $9,$1,$2
        exp_exe(12'h100, 32'd5, 32'd1);
        exp_wb(5'd9, 32'h00000020, 1'b1, 1'b0, 1'b0, 2);
        issue(32'h00224804, 32'd5, 32'd1, a0);

        // illegal opcode
        exp_wb(5'd0, 32'h0, 1'b0, 1'b1, 1'b0, 1);
        issue(32'hFC000000, 32'h1, 32'h2, a0);

        // addu $0: record delivered, no write
        exp_exe(12'h001, 32'd20, 32'd22);
        exp_wb(5'd0, 32'd42, 1'b0, 1'b0, 1'b0, 2);
        issue(32'h00220021, 32'd20, 32'd22, a0);

        // add $3,$1,$2 with signed overflow
        exp_exe(12'h001, 32'h7FFFFFFF, 32'h1);
`ifdef ALU_ISSUE_OVF_EN
        exp_wb(5'd3, 32'h80000000, 1'b0, 1'b0, 1'b1, 2);
`else
        exp_wb(5'd3, 32'h80000000, 1'b1, 1'b0, 1'b0, 2);
`endif
        issue(32'h00221820, 32'h7FFFFFFF, 32'h1, a0);
        drain();

        // and $7,$1,$2 with wb_ready held low for 5 cycles
        wb_ready = 1'b0;
        exp_exe(12'h010, 32'h0000F0F0, 32'h0000FF00);
        exp_wb(5'd7, 32'h0000F000, 1'b1, 1'b0, 1'b0, 2);
        issue(32'h00223824, 32'h0000F0F0, 32'h0000FF00, a0);
        begin
            int n;
            n = 0;
            while (!wb_valid && n < 20) begin
                @(negedge clk);
                n++;
            end
            chk("stall wb_valid", {31'b0, wb_valid}, 32'h1);
        end
        repeat (5) @(negedge clk);
        @(posedge clk);
        #1 wb_ready = 1'b1;
        drain();

        // xor $8,$1,$2 killed by reset in EXE
        exp_exe(12'h080, 32'h0000F0F0, 32'h00000FF0);
        issue(32'h00224026, 32'h0000F0F0, 32'h00000FF0, a0);
        @(negedge clk);
        @(negedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
        chk_all_zero("mid-exe reset");
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("post-reset wb_valid", {31'b0, wb_valid}, 32'h0);
        end

        // subu $9,$1,$2 after reset recovery
        exp_exe(12'h002, 32'd10, 32'd3);
        exp_wb(5'd9, 32'd7, 1'b1, 1'b0, 1'b0, 2);
        issue(32'h00224823, 32'd10, 32'd3, a0);
        drain();

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
